// File: rtl/bsg_mem_1rw_sync_rv_front.sv
// rtl/bsg_mem_1rw_sync_rv_front.sv - ready/valid front end for a 1RW sync RAM (optional BSG_MEM_1RW_SYNC_RV_BYPASS_EN)
module bsg_mem_1rw_sync_rv_front #(
  parameter int width_p = 64,
  parameter int els_p = 512,
  parameter int fifo_els_p = 3,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  // One spare value so count + inflight can be compared without overflow.
  localparam int cnt_w_lp = $clog2(fifo_els_p + 2);

  if (fifo_els_p < 1) begin : g_bad_depth
    $error("fifo_els_p must be >= 1");
  end

  logic [cnt_w_lp-1:0] count_r, count_n;
  logic                inflight_r;
  logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
  logic [width_p-1:0]  buf_r [0:fifo_els_p-1];

  logic accept;
  logic fifo_nonempty;
  logic enq, deq;

  function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Credits: a read may issue only if its response is guaranteed a buffer slot.
  assign ready_o = (count_r + cnt_w_lp'(inflight_r)) < cnt_w_lp'(fifo_els_p);
  assign accept  = v_i & ready_o;

  assign mem_v_o    = accept & reset_n_i;
  assign mem_w_o    = w_i;
  assign mem_addr_o = addr_i;
  assign mem_data_o = data_i;

  assign fifo_nonempty = (count_r != '0);
  assign deq           = yumi_i & fifo_nonempty;

`ifdef BSG_MEM_1RW_SYNC_RV_BYPASS_EN
  logic bypass;
  // Empty buffer with a read landing: hand RAM output straight to the consumer.
  assign bypass = ~fifo_nonempty & inflight_r;
  assign v_o    = fifo_nonempty | bypass;
  assign data_o = bypass ? mem_data_i : buf_r[rd_ptr_r];
  assign enq    = inflight_r & ~(bypass & yumi_i);
`else
  assign v_o    = fifo_nonempty;
  assign data_o = buf_r[rd_ptr_r];
  assign enq    = inflight_r;
`endif

  // Occupancy update from enqueue of landed read data and consumer dequeue.
  always_comb begin
    count_n = count_r;
    count_n = count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
  end

  // Tracking state and response buffer; reset discards every pending response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r    <= '0;
      inflight_r <= 1'b0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      for (int i = 0; i < fifo_els_p; i++) buf_r[i] <= '0;
    end else begin
      count_r    <= count_n;
      inflight_r <= accept & ~w_i;
      if (enq) begin
        buf_r[wr_ptr_r] <= mem_data_i;
        wr_ptr_r        <= wrap_inc(wr_ptr_r);
      end
      if (deq) rd_ptr_r <= wrap_inc(rd_ptr_r);
    end
  end

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) count_r <= cnt_w_lp'(fifo_els_p));

endmodule
